// File: rtl/riscv_ctrl_mc_pkg.sv
// Shared encodings for the multi-cycle RV32I controller: FSM states, datapath
// select codes, ALU operations and major opcodes.
package riscv_ctrl_mc_pkg;

  typedef enum logic [1:0] {ST_FETCH, ST_EXEC, ST_MEM, ST_TRAP} state_t;

  typedef enum logic [1:0] {PC_ALU = 2'd0, PC_IMM = 2'd1, PC_PC4 = 2'd2} src_pc_t;
  typedef enum logic [1:0] {RD_MEM = 2'd0, RD_IMM = 2'd1, RD_PC4 = 2'd2, RD_ALU = 2'd3} src_rd_t;
  typedef enum logic {A_PC = 1'b0, A_RS1 = 1'b1} src_a_t;
  typedef enum logic {B_IMM = 1'b0, B_RS2 = 1'b1} src_b_t;
  typedef enum logic [2:0] {IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_J = 3'd3, IMM_U = 3'd4} imm_t;
  typedef enum logic [3:0] {
    ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3, ALU_SLTU = 4'd4,
    ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7, ALU_OR = 4'd8, ALU_AND = 4'd9
  } alu_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  // alt selects SUB for funct3=000 and SRA for funct3=101
  function automatic alu_t alu_op(input logic [2:0] funct3, input logic alt);
    case (funct3)
      3'b000:  alu_op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  alu_op = ALU_SLL;
      3'b010:  alu_op = ALU_SLT;
      3'b011:  alu_op = ALU_SLTU;
      3'b100:  alu_op = ALU_XOR;
      3'b101:  alu_op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_op = ALU_OR;
      default: alu_op = ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/riscv_ctrl_mc_decoder.sv
// Combinational RV32I decoder: datapath selects, ALU control, and instruction
// class flags (writes rd, memory access, store, illegal).
module riscv_decoder
  import riscv_ctrl_mc_pkg::*;
(
  input  logic [31:0] instr,
  input  logic        alu_zero,
  output logic [1:0]  src_pc,
  output logic [2:0]  src_imm,
  output logic [1:0]  src_rd,
  output logic        src_alu_a,
  output logic        src_alu_b,
  output logic [3:0]  alu_ctrl,
  output logic        wr_rd,
  output logic        is_mem,
  output logic        is_store,
  output logic        illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       taken;
  logic       unused_fields;

  assign opcode        = instr[6:0];
  assign funct3        = instr[14:12];
  assign funct7        = instr[31:25];
  assign unused_fields = ^{instr[24:15], instr[11:7]};

  // BEQ/BGE/BGEU take on zero, BNE/BLT/BLTU on non-zero
  assign taken = alu_zero ^ (funct3[0] ^ funct3[2]);

  always_comb begin
    src_pc    = PC_PC4;
    src_imm   = IMM_I;
    src_rd    = RD_ALU;
    src_alu_a = A_RS1;
    src_alu_b = B_IMM;
    alu_ctrl  = ALU_ADD;
    wr_rd     = 1'b0;
    is_mem    = 1'b0;
    is_store  = 1'b0;
    illegal   = 1'b0;
    case (opcode)
      OPC_OP: begin
        src_alu_b = B_RS2;
        wr_rd     = 1'b1;
        alu_ctrl  = alu_op(funct3, funct7[5]);
        illegal   = !(funct7 == 7'h00 ||
                      (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101)));
      end
      OPC_OP_IMM: begin
        wr_rd    = 1'b1;
        alu_ctrl = alu_op(funct3, funct3 == 3'b101 && funct7[5]);
        if (funct3 == 3'b001)
          illegal = funct7 != 7'h00;
        else if (funct3 == 3'b101)
          illegal = funct7 != 7'h00 && funct7 != 7'h20;
      end
      OPC_LOAD: begin
        is_mem  = 1'b1;
        wr_rd   = 1'b1;
        src_rd  = RD_MEM;
        illegal = funct3 == 3'b011 || funct3[2:1] == 2'b11;
      end
      OPC_STORE: begin
        is_mem   = 1'b1;
        is_store = 1'b1;
        src_imm  = IMM_S;
        illegal  = funct3[2] || funct3 == 3'b011;
      end
      OPC_BRANCH: begin
        src_alu_b = B_RS2;
        src_imm   = IMM_B;
        src_pc    = taken ? PC_IMM : PC_PC4;
        case (funct3[2:1])
          2'b00:   alu_ctrl = ALU_SUB;
          2'b10:   alu_ctrl = ALU_SLT;
          2'b11:   alu_ctrl = ALU_SLTU;
          default: illegal  = 1'b1;
        endcase
      end
      OPC_JAL: begin
        src_pc  = PC_IMM;
        src_rd  = RD_PC4;
        src_imm = IMM_J;
        wr_rd   = 1'b1;
      end
      OPC_JALR: begin
        src_pc  = PC_ALU;
        src_rd  = RD_PC4;
        wr_rd   = 1'b1;
        illegal = funct3 != 3'b000;
      end
      OPC_LUI: begin
        src_rd  = RD_IMM;
        src_imm = IMM_U;
        wr_rd   = 1'b1;
      end
      OPC_AUIPC: begin
        src_alu_a = A_PC;
        src_imm   = IMM_U;
        wr_rd     = 1'b1;
      end
      OPC_FENCE: illegal = funct3 != 3'b000;
      default:   illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/riscv_ctrl_mc.sv
// Multi-cycle RV32I controller: req/ack fetch into an instruction register,
// decode, req/ack load/store sequencing, PC-enable gating and illegal-op trap.
module riscv_ctrl_mc
  import riscv_ctrl_mc_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_ctrl_imem_ack,
  input  logic [31:0] i_ctrl_imem_data,
  input  logic        i_ctrl_dmem_ack,
  input  logic        i_ctrl_alu_zero,
  output logic        o_ctrl_imem_req,
  output logic        o_ctrl_dmem_req,
  output logic        o_ctrl_dmem_we,
  output logic [2:0]  o_ctrl_dmem_size,
  output logic [31:0] o_ctrl_instr,
  output logic        o_ctrl_pc_en,
  output logic [1:0]  o_ctrl_src_pc,
  output logic [2:0]  o_ctrl_src_imm,
  output logic [1:0]  o_ctrl_src_rd,
  output logic        o_ctrl_src_alu_a,
  output logic        o_ctrl_src_alu_b,
  output logic        o_ctrl_reg_wr_en,
  output logic [3:0]  o_ctrl_alu_ctrl,
  output logic        o_ctrl_retire,
  output logic        o_ctrl_trap
);

  state_t state, state_nxt;
  logic   instr_ld;
  logic   wr_rd, is_mem, is_store, illegal;

  riscv_decoder u_decoder (
    .instr     (o_ctrl_instr),
    .alu_zero  (i_ctrl_alu_zero),
    .src_pc    (o_ctrl_src_pc),
    .src_imm   (o_ctrl_src_imm),
    .src_rd    (o_ctrl_src_rd),
    .src_alu_a (o_ctrl_src_alu_a),
    .src_alu_b (o_ctrl_src_alu_b),
    .alu_ctrl  (o_ctrl_alu_ctrl),
    .wr_rd     (wr_rd),
    .is_mem    (is_mem),
    .is_store  (is_store),
    .illegal   (illegal)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= ST_FETCH;
      o_ctrl_instr <= NOP_INSTR;
    end else begin
      state <= state_nxt;
      if (instr_ld)
        o_ctrl_instr <= i_ctrl_imem_data;
    end
  end

  assign o_ctrl_dmem_size = o_ctrl_instr[14:12];
  assign o_ctrl_trap      = state == ST_TRAP;

  // Strobes are masked while reset is asserted so a pending access is dropped
  // in the reset cycle itself; req then rises in the first cycle out of reset.
  always_comb begin
    state_nxt        = state;
    instr_ld         = 1'b0;
    o_ctrl_imem_req  = 1'b0;
    o_ctrl_dmem_req  = 1'b0;
    o_ctrl_dmem_we   = 1'b0;
    o_ctrl_pc_en     = 1'b0;
    o_ctrl_reg_wr_en = 1'b0;
    o_ctrl_retire    = 1'b0;
    if (!i_rst) begin
      case (state)
        ST_FETCH: begin
          o_ctrl_imem_req = 1'b1;
          if (i_ctrl_imem_ack) begin
            instr_ld  = 1'b1;
            state_nxt = ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (illegal) begin
            state_nxt = ST_TRAP;
          end else if (is_mem) begin
            state_nxt = ST_MEM;
          end else begin
            o_ctrl_pc_en     = 1'b1;
            o_ctrl_retire    = 1'b1;
            o_ctrl_reg_wr_en = wr_rd;
            state_nxt        = ST_FETCH;
          end
        end
        ST_MEM: begin
          o_ctrl_dmem_req = 1'b1;
          o_ctrl_dmem_we  = is_store;
          if (i_ctrl_dmem_ack) begin
            o_ctrl_pc_en     = 1'b1;
            o_ctrl_retire    = 1'b1;
            o_ctrl_reg_wr_en = !is_store;
            state_nxt        = ST_FETCH;
          end
        end
        default: state_nxt = ST_TRAP;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_ctrl_mc.sv
// Directed bench for riscv_ctrl_mc: inputs change on the falling edge and
// outputs are checked 1ns later, well away from the rising (active) edge.
module tb_riscv_ctrl_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic        dmem_ack;
  logic        alu_zero;
  logic        imem_req, dmem_req, dmem_we, pc_en, src_alu_a, src_alu_b;
  logic        reg_wr_en, retire, trap;
  logic [2:0]  dmem_size, src_imm;
  logic [31:0] instr;
  logic [1:0]  src_pc, src_rd;
  logic [3:0]  alu_ctrl;

  int checks   = 0;
  int failures = 0;

  riscv_ctrl_mc #(.NOP_INSTR(32'h0000_0013)) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_ctrl_imem_ack  (imem_ack),
    .i_ctrl_imem_data (imem_data),
    .i_ctrl_dmem_ack  (dmem_ack),
    .i_ctrl_alu_zero  (alu_zero),
    .o_ctrl_imem_req  (imem_req),
    .o_ctrl_dmem_req  (dmem_req),
    .o_ctrl_dmem_we   (dmem_we),
    .o_ctrl_dmem_size (dmem_size),
    .o_ctrl_instr     (instr),
    .o_ctrl_pc_en     (pc_en),
    .o_ctrl_src_pc    (src_pc),
    .o_ctrl_src_imm   (src_imm),
    .o_ctrl_src_rd    (src_rd),
    .o_ctrl_src_alu_a (src_alu_a),
    .o_ctrl_src_alu_b (src_alu_b),
    .o_ctrl_reg_wr_en (reg_wr_en),
    .o_ctrl_alu_ctrl  (alu_ctrl),
    .o_ctrl_retire    (retire),
    .o_ctrl_trap      (trap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One fetch cycle with zero-wait ack; returns 1ns into the EXEC cycle.
  task automatic do_fetch(input logic [31:0] ins);
    @(negedge clk);
    imem_ack  = 1'b1;
    imem_data = ins;
    #1;
    chk("fetch_req", {31'b0, imem_req}, 1);
    chk("fetch_no_pc_en", {31'b0, pc_en}, 0);
    @(negedge clk);
    imem_ack  = 1'b0;
    imem_data = '0;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; imem_ack = 1'b0; imem_data = '0; dmem_ack = 1'b0; alu_zero = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_imem_req", {31'b0, imem_req}, 0);
    chk("rst_dmem_req", {31'b0, dmem_req}, 0);
    chk("rst_dmem_we", {31'b0, dmem_we}, 0);
    chk("rst_pc_en", {31'b0, pc_en}, 0);
    chk("rst_reg_wr_en", {31'b0, reg_wr_en}, 0);
    chk("rst_retire", {31'b0, retire}, 0);
    chk("rst_trap", {31'b0, trap}, 0);
    chk("rst_instr", instr, 32'h13);

    // Reset release, one imem wait state
    @(negedge clk); rst = 1'b0; #1;
    chk("rel_imem_req", {31'b0, imem_req}, 1);
    chk("rel_instr", instr, 32'h13);
    @(negedge clk); #1;
    chk("wait_imem_req", {31'b0, imem_req}, 1);
    chk("wait_instr", instr, 32'h13);

    // addi x1,x0,5
    do_fetch(32'h0050_0093);
    chk("addi_instr", instr, 32'h0050_0093);
    chk("addi_alu_b", {31'b0, src_alu_b}, 0);
    chk("addi_alu", {28'b0, alu_ctrl}, 0);
    chk("addi_src_rd", {30'b0, src_rd}, 3);
    chk("addi_wr", {31'b0, reg_wr_en}, 1);
    chk("addi_pc_en", {31'b0, pc_en}, 1);
    chk("addi_retire", {31'b0, retire}, 1);
    chk("addi_imem_req", {31'b0, imem_req}, 0);

    // sub x3,x1,x2 back-to-back
    do_fetch(32'h4020_81B3);
    chk("sub_alu_b", {31'b0, src_alu_b}, 1);
    chk("sub_alu", {28'b0, alu_ctrl}, 1);
    chk("sub_retire", {31'b0, retire}, 1);

    // beq taken
    alu_zero = 1'b1;
    do_fetch(32'h0020_8463);
    chk("beq_src_pc", {30'b0, src_pc}, 1);
    chk("beq_alu", {28'b0, alu_ctrl}, 1);
    chk("beq_imm", {29'b0, src_imm}, 2);
    chk("beq_wr", {31'b0, reg_wr_en}, 0);
    chk("beq_pc_en", {31'b0, pc_en}, 1);

    // bne not taken (zero=1)
    do_fetch(32'h0020_9463);
    chk("bne_src_pc", {30'b0, src_pc}, 2);

    // bltu taken (zero=0)
    alu_zero = 1'b0;
    do_fetch(32'h0020_E463);
    chk("bltu_alu", {28'b0, alu_ctrl}, 4);
    chk("bltu_src_pc", {30'b0, src_pc}, 1);

    // jal x1,8
    do_fetch(32'h0080_00EF);
    chk("jal_src_pc", {30'b0, src_pc}, 1);
    chk("jal_src_rd", {30'b0, src_rd}, 2);
    chk("jal_imm", {29'b0, src_imm}, 3);
    chk("jal_wr", {31'b0, reg_wr_en}, 1);

    // jalr x0,0(x1)
    do_fetch(32'h0000_8067);
    chk("jalr_src_pc", {30'b0, src_pc}, 0);
    chk("jalr_src_rd", {30'b0, src_rd}, 2);

    // lui x5,0x12345
    do_fetch(32'h1234_52B7);
    chk("lui_src_rd", {30'b0, src_rd}, 1);
    chk("lui_imm", {29'b0, src_imm}, 4);

    // auipc x2,1
    do_fetch(32'h0000_1117);
    chk("auipc_alu_a", {31'b0, src_alu_a}, 0);
    chk("auipc_alu_b", {31'b0, src_alu_b}, 0);
    chk("auipc_src_rd", {30'b0, src_rd}, 3);

    // lw x5,4(x1) with ack on the third MEM cycle
    do_fetch(32'h0040_A283);
    chk("lw_exec_pc_en", {31'b0, pc_en}, 0);
    chk("lw_exec_wr", {31'b0, reg_wr_en}, 0);
    chk("lw_exec_dmem_req", {31'b0, dmem_req}, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      chk("lw_wait_req", {31'b0, dmem_req}, 1);
      chk("lw_wait_we", {31'b0, dmem_we}, 0);
      chk("lw_wait_size", {29'b0, dmem_size}, 3'b010);
      chk("lw_wait_pc_en", {31'b0, pc_en}, 0);
      chk("lw_wait_wr", {31'b0, reg_wr_en}, 0);
    end
    @(negedge clk); dmem_ack = 1'b1; #1;
    chk("lw_ack_req", {31'b0, dmem_req}, 1);
    chk("lw_ack_pc_en", {31'b0, pc_en}, 1);
    chk("lw_ack_wr", {31'b0, reg_wr_en}, 1);
    chk("lw_ack_src_rd", {30'b0, src_rd}, 0);
    chk("lw_ack_retire", {31'b0, retire}, 1);
    @(negedge clk); dmem_ack = 1'b0; #1;
    chk("lw_done_dmem_req", {31'b0, dmem_req}, 0);
    chk("lw_done_imem_req", {31'b0, imem_req}, 1);

    // dmem ack while no data request is outstanding
    @(negedge clk); dmem_ack = 1'b1; #1;
    chk("stray_ack_pc_en", {31'b0, pc_en}, 0);
    chk("stray_ack_retire", {31'b0, retire}, 0);
    @(negedge clk); dmem_ack = 1'b0; #1;
    chk("stray_ack_fetch", {31'b0, imem_req}, 1);
    chk("stray_ack_dmem_req", {31'b0, dmem_req}, 0);

    // sw x2,8(x1) stalled, then reset in MEM and a late ack
    do_fetch(32'h0020_A423);
    chk("sw_exec_pc_en", {31'b0, pc_en}, 0);
    @(negedge clk); #1;
    chk("sw_req", {31'b0, dmem_req}, 1);
    chk("sw_we", {31'b0, dmem_we}, 1);
    chk("sw_size", {29'b0, dmem_size}, 3'b010);
    chk("sw_pc_en", {31'b0, pc_en}, 0);
    @(negedge clk); rst = 1'b1; #1;
    chk("sw_rst_dmem_req", {31'b0, dmem_req}, 0);
    @(negedge clk); rst = 1'b0; dmem_ack = 1'b1; #1;
    chk("late_ack_dmem_req", {31'b0, dmem_req}, 0);
    chk("late_ack_imem_req", {31'b0, imem_req}, 1);
    chk("late_ack_pc_en", {31'b0, pc_en}, 0);
    chk("late_ack_retire", {31'b0, retire}, 0);
    chk("late_ack_instr", instr, 32'h13);
    @(negedge clk); dmem_ack = 1'b0; #1;
    chk("after_rst_fetch", {31'b0, imem_req}, 1);

    // Illegal opcode parks the core
    do_fetch(32'h0000_0000);
    chk("ill_exec_pc_en", {31'b0, pc_en}, 0);
    chk("ill_exec_retire", {31'b0, retire}, 0);
    chk("ill_exec_wr", {31'b0, reg_wr_en}, 0);
    @(negedge clk); imem_ack = 1'b1; imem_data = 32'h0050_0093; #1;
    chk("trap_flag", {31'b0, trap}, 1);
    chk("trap_imem_req", {31'b0, imem_req}, 0);
    repeat (3) @(negedge clk);
    #1;
    chk("trap_sticky", {31'b0, trap}, 1);
    chk("trap_no_req", {31'b0, imem_req}, 0);
    chk("trap_no_pc_en", {31'b0, pc_en}, 0);
    chk("trap_instr", instr, 32'h0);
    imem_ack = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; #1;
    chk("trap_cleared", {31'b0, trap}, 0);
    chk("trap_rst_imem_req", {31'b0, imem_req}, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/riscv_ctrl_mc.md
# riscv_ctrl_mc

Multi-cycle controller for the RV32I datapath (`riscv_datapath`). It fetches over a req/ack instruction port and holds the instruction in its own instruction register. It decodes the instruction into the datapath mux selects, ALU control and register-file write enable, sequences load/store accesses over a req/ack data port, and gates the PC register enable, so memories with arbitrary wait states are supported. Illegal opcodes park the core in a trap state until reset.

## Interface
- `NOP_INSTR`, default `32'h0000_0013`: reset value of the instruction register (`addi x0,x0,0`).
- `i_clk`  in  1  clock.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_ctrl_imem_ack`  in  1  instruction valid on `i_ctrl_imem_data`; may assert in the same cycle as req.
- `i_ctrl_imem_data`  in  32  fetched instruction.
- `i_ctrl_dmem_ack`  in  1  data access complete; load data valid on the datapath mem read input.
- `i_ctrl_alu_zero`  in  1  ALU zero flag from the datapath.
- `o_ctrl_imem_req`  out  1  fetch request; PC addresses imem.
- `o_ctrl_dmem_req`  out  1  data access request.
- `o_ctrl_dmem_we`  out  1  store when 1.
- `o_ctrl_dmem_size`  out  3  `funct3` of the load/store.
- `o_ctrl_instr`  out  32  instruction register; drives the datapath instruction input.
- `o_ctrl_pc_en`  out  1  PC register enable.
- `o_ctrl_src_pc`  out  2  next-PC select.
- `o_ctrl_src_imm`  out  3  immediate format select.
- `o_ctrl_src_rd`  out  2  rd write-data select.
- `o_ctrl_src_alu_a`  out  1  ALU operand A select.
- `o_ctrl_src_alu_b`  out  1  ALU operand B select.
- `o_ctrl_reg_wr_en`  out  1  register-file write enable.
- `o_ctrl_alu_ctrl`  out  4  ALU operation.
- `o_ctrl_retire`  out  1  one-cycle pulse per retired instruction.
- `o_ctrl_trap`  out  1  sticky illegal-instruction flag.

## Operation
- **Encodings** (fixed):
  - `src_pc`: ALU=0, PC+IMM=1, PC+4=2.
  - `src_rd`: MEM=0, IMM=1, PC+4=2, ALU=3.
  - `src_alu_a`: PC=0, RS1=1.
  - `src_alu_b`: IMM=0, RS2=1.
  - `src_imm`: I=0, S=1, B=2, J=3, U=4.
  - `alu_ctrl`: ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9.
- **FSM states**: FETCH, EXEC, MEM, TRAP.
- **FETCH**:
  - Assert `imem_req`.
  - On ack: latch `i_ctrl_imem_data` into `o_ctrl_instr`, go to EXEC.
  - Without ack: remain in FETCH with req held.
- **EXEC**:
  - OP, OP-IMM, LUI, AUIPC, JAL, JALR, BRANCH, FENCE: assert `pc_en` and `retire` for one cycle, plus `reg_wr_en` when the instruction writes rd; then go to FETCH.
  - LOAD/STORE: ALU computes rs1+imm; go to MEM with no `pc_en`.
  - Any other opcode, or an illegal funct: go to TRAP.
- **Branches**:
  - BEQ/BNE use SUB.
  - BLT/BGE use SLT; BLTU/BGEU use SLTU.
  - Taken condition: `zero` for BEQ/BGE/BGEU, `!zero` for BNE/BLT/BLTU.
  - Taken → `src_pc`=PC+IMM; not taken → PC+4.
- **Jumps**:
  - JAL: `src_pc`=PC+IMM, `src_rd`=PC+4.
  - JALR: `src_pc`=ALU (rs1+imm), `src_rd`=PC+4. No LSB clearing.
- **U-type**:
  - LUI: `src_rd`=IMM.
  - AUIPC: `src_alu_a`=PC, `src_alu_b`=IMM, ALU=ADD, `src_rd`=ALU.
- **MEM**:
  - Hold `dmem_req`, `dmem_we` (1 for store) and `dmem_size`, with `src_alu_a`=RS1, `src_alu_b`=IMM and ALU=ADD, until ack.
  - On ack, in the same cycle: `pc_en`=1, `retire`=1, `reg_wr_en`=1 for loads with `src_rd`=MEM; then go to FETCH.
- **TRAP**:
  - All strobes are 0 and `o_ctrl_trap`=1.
  - The controller exits TRAP only on reset.
- **Write-enable rules**:
  - `reg_wr_en` is never asserted outside EXEC/MEM.
  - Writes to x0 are allowed; the register file ignores them.

## Timing
- **Reset**:
  - Sync reset dominates every state, including a pending req/ack; pending requests are dropped.
  - Reset values: state=FETCH, `o_ctrl_instr`=`NOP_INSTR`, `o_ctrl_trap`=0, all strobes (`imem_req`, `dmem_req`, `dmem_we`, `pc_en`, `reg_wr_en`, `retire`)=0.
- `imem_req` rises in the first cycle after `i_rst` deasserts.
- Control selects are combinational from state and `o_ctrl_instr`. They are don't-care whenever `pc_en` and `reg_wr_en` are both 0.
- **Latency with zero-wait memories** (ack in the same cycle as req):
  - Non-memory instructions: 2 cycles (FETCH, EXEC).
  - Load/store: 3 cycles (FETCH, EXEC, MEM).
- Each extra wait cycle on either port adds exactly one cycle.
- **Protocol error**: ack without req is ignored.

## Structure
- **Shared definitions**: all encodings above go as `` `define`` constants in `riscv_configs.v`, alongside the opcode values `OP`, `OP_IMM`, `LOAD`, `STORE`, `BRANCH`, `JAL`, `JALR`, `LUI`, `AUIPC`, `FENCE`.
- **Sub-module** `riscv_decoder`: purely combinational. Inputs: instruction and `alu_zero`. Outputs: `src_*` selects, `alu_ctrl`, writes-rd, is-mem, is-store and illegal.
- **`riscv_ctrl_mc` itself**: the FSM, the instruction register and the strobe gating.
- **Datapath change**: the datapath PC register enable is driven by `o_ctrl_pc_en` instead of a constant 1.

## Test plan
- **Reset release**: `i_rst` 1→0 → `imem_req`=1 the next cycle. `o_ctrl_instr`=`32'h13` until the first ack.
- **Back-to-back ALU ops**: `addi x1,x0,5` (`32'h00500093`) with zero-wait ack → EXEC asserts `src_alu_b`=0, `alu_ctrl`=0, `src_rd`=3, `reg_wr_en`=1, `pc_en`=1. `retire` pulses every 2 cycles.
- **Branches**: `beq` with `i_ctrl_alu_zero`=1 → `src_pc`=1. `bne` with zero=1 → `src_pc`=2. `bltu` → `alu_ctrl`=4.
- **Load with wait states**: `lw` with dmem ack after 3 cycles → `dmem_req` high for 3 cycles with `dmem_we`=0 and `dmem_size`=`3'b010`. `reg_wr_en`, `src_rd`=0 and `pc_en` fire only in the ack cycle.
- **Illegal opcode**: `32'h0000_0000` → TRAP. `o_ctrl_trap`=1, no further `imem_req`; reset clears the trap.
- **Reset mid-operation**: reset during MEM with a stalled store → the next cycle has `dmem_req`=0 and state=FETCH. A late ack is ignored.
